// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
// Holds the register-file geometry defaults (shared with the CPU register
// file) and the sequencer state encoding.
package regfile_dump_reader_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    FIN
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bus bundle for the dump reader.
// The bundle covers the spare register-file read port and the outgoing word
// stream.
//   rf_a       read address to the register file
//   rf_rd      asynchronous read data returned by the register file
//   dout_valid stream word valid
//   dout_ready downstream accepts the word
//   dout_data  register value
//   dout_idx   register index of dout_data
//   dout_last  marks the word for the last dumped register
// The master modport is the reader. The slave modport is the register file
// plus the stream consumer.
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_rd;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W-1:0] dout_idx;
  logic              dout_last;

  modport master (
    output rf_a,
    input  rf_rd,
    output dout_valid,
    input  dout_ready,
    output dout_data,
    output dout_idx,
    output dout_last
  );

  modport slave (
    input  rf_a,
    output rf_rd,
    input  dout_valid,
    output dout_ready,
    input  dout_data,
    input  dout_idx,
    input  dout_last
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Debug readout sequencer for the register file.
// On start, it walks register indices FIRST_REG..LAST_REG in ascending order.
// For each index it reads the register through a spare asynchronous read port
// and presents the value as one stream word. The block never writes the
// register file.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   start  begin a dump (only honoured in IDLE)
//   abort  synchronous abort back to IDLE
//   busy   high in every state except IDLE
//   done   one-cycle pulse after the final handshake
//   bus    read port and output stream (master side)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; read address parked at FIRST_REG
// LOAD  | address = idx; capture rf_rd into the output word register
// SEND  | word valid and held until the consumer accepts it
// FIN   | done pulse; index reloads to FIRST_REG
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = NUM_REGS - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  regfile_dump_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  dump_state_t       state;
  dump_state_t       state_next;
  logic [ADDR_W-1:0] idx;
  logic              load_word;
  logic              take_word;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;

  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    take_word  = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        load_word  = 1'b1;
        state_next = SEND;
      end
      SEND: if (bus.dout_ready) begin
        take_word  = 1'b1;
        state_next = out_last ? FIN : LOAD;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides start and the handshake.
    // The consumer may still see an accepted word, but nothing else advances.
    if (abort) begin
      state_next = IDLE;
      load_word  = 1'b0;
      take_word  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= FIRST_IDX;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_next;
      if (abort) begin
        idx       <= FIRST_IDX;
        out_valid <= 1'b0;
      end else begin
        if (load_word) begin
          out_data  <= bus.rf_rd;
          out_idx   <= idx;
          out_last  <= (idx == LAST_IDX);
          out_valid <= 1'b1;
        end
        // The increment is skipped on the last word.
        // This keeps idx from wrapping when LAST_REG is the top index.
        if (take_word) begin
          out_valid <= 1'b0;
          if (!out_last) idx <= idx + ADDR_W'(1);
        end
        if (state == FIN) idx <= FIRST_IDX;
      end
    end
  end

  assign bus.rf_a       = idx;
  assign bus.dout_valid = out_valid;
  assign bus.dout_data  = out_data;
  assign bus.dout_idx   = out_idx;
  assign bus.dout_last  = out_last;
  assign busy           = (state != IDLE);
  assign done           = (state == FIN);

endmodule
